// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data BRAM port arbiter:
// read-return owner codes, grant encoding and the owner update helper.
package mem_port_arbiter_pkg;

   localparam logic [1:0] ARB_OWN_NONE = 2'b00;
   localparam logic [1:0] ARB_OWN_I    = 2'b01;
   localparam logic [1:0] ARB_OWN_D    = 2'b10;

   typedef enum logic [1:0] {
      GNT_NONE = 2'b00,
      GNT_I    = 2'b01,
      GNT_D    = 2'b10
   } gnt_e;

   // Only reads own a return slot; a data write leaves the port free next cycle.
   function automatic logic [1:0] owner_next(input gnt_e gnt, input logic we);
      logic [1:0] own;
      case (gnt)
         GNT_I:   own = ARB_OWN_I;
         GNT_D:   own = we ? ARB_OWN_NONE : ARB_OWN_D;
         default: own = ARB_OWN_NONE;
      endcase
      return own;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares a single bram32 port between instruction fetch and data load/store.
// Data wins by default; a bounded run of data grants guarantees fetch progress.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 32,
   parameter int MAX_DATA_RUN = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_be,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] m_addr,
   output logic              m_r_enb,
   output logic              m_w_enb,
   output logic [DATA_W-1:0] m_w_dat,
   output logic [3:0]        m_byte_enb,
   input  logic [DATA_W-1:0] m_r_dat
);

   localparam int               RUN_W   = $clog2(MAX_DATA_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

   logic [RUN_W-1:0] run_r;
   logic [RUN_W-1:0] run_nxt_s;
   logic [1:0]       owner_r;
   gnt_e             gnt_s;

   // Grant selection; reset holds the port idle combinationally.
   always_comb begin
      gnt_s = GNT_NONE;
      if (!rst_n) begin
         gnt_s = GNT_NONE;
      end else if (d_req && !(i_req && (run_r == RUN_MAX))) begin
         gnt_s = GNT_D;
      end else if (i_req) begin
         gnt_s = GNT_I;
      end else begin
         gnt_s = GNT_NONE;
      end
   end

   // Drive the BRAM port from the winning requester.
   always_comb begin
      i_gnt      = 1'b0;
      d_gnt      = 1'b0;
      m_addr     = i_addr;
      m_r_enb    = 1'b0;
      m_w_enb    = 1'b0;
      m_w_dat    = {DATA_W{1'b0}};
      m_byte_enb = 4'b0000;
      case (gnt_s)
         GNT_D: begin
            d_gnt      = 1'b1;
            m_addr     = d_addr;
            m_w_enb    = d_we;
            m_r_enb    = ~d_we;
            m_w_dat    = d_wdata;
            m_byte_enb = d_be;
         end
         GNT_I: begin
            i_gnt   = 1'b1;
            m_r_enb = 1'b1;
         end
         default: begin
            m_r_enb = 1'b0;
         end
      endcase
   end

   // Consecutive data grants seen by a waiting fetch, saturating at the limit.
   always_comb begin
      run_nxt_s = run_r;
      if ((gnt_s == GNT_I) || !i_req) begin
         run_nxt_s = {RUN_W{1'b0}};
      end else if ((gnt_s == GNT_D) && (run_r != RUN_MAX)) begin
         run_nxt_s = run_r + RUN_W'(1);
      end else begin
         run_nxt_s = run_r;
      end
   end

   // Run counter and read-return owner; reset drops any in-flight return.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_r   <= {RUN_W{1'b0}};
         owner_r <= ARB_OWN_NONE;
      end else begin
         run_r   <= run_nxt_s;
         owner_r <= owner_next(gnt_s, d_we);
      end
   end

   assign i_rvalid = owner_r[0];
   assign d_rvalid = owner_r[1];
   assign i_rdata  = m_r_dat;
   assign d_rdata  = m_r_dat;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a BRAM model on the memory side,
// directed scenarios followed by random traffic against a reference model.
module tb_mem_port_arbiter;

   localparam int AW      = 12;
   localparam int DW      = 32;
   localparam int MAX_RUN = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_req, d_req, d_we;
   logic [AW-1:0] i_addr, d_addr, m_addr;
   logic [DW-1:0] d_wdata, i_rdata, d_rdata, m_w_dat, m_r_dat;
   logic [3:0]    d_be, m_byte_enb;
   logic          i_gnt, d_gnt, i_rvalid, d_rvalid, m_r_enb, m_w_enb;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: memory image, waiting-fetch data run, expected return.
   logic [DW-1:0] ref_mem [0:4095];
   logic [DW-1:0] bram    [0:4095];
   int            ref_run;
   logic          exp_rv_i, exp_rv_d;
   logic [DW-1:0] exp_rdata;
   logic          obs_i_gnt, obs_d_gnt, obs_d_rvalid;
   logic [DW-1:0] obs_d_rdata;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_RUN(MAX_RUN)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_addr(m_addr), .m_r_enb(m_r_enb), .m_w_enb(m_w_enb), .m_w_dat(m_w_dat),
      .m_byte_enb(m_byte_enb), .m_r_dat(m_r_dat)
   );

   always #5 clk = ~clk;

   // bram32 behaviour: byte-masked write, registered read.
   always @(posedge clk) begin
      if (m_w_enb) begin
         for (int b = 0; b < 4; b++) begin
            if (m_byte_enb[b]) bram[m_addr][8*b +: 8] <= m_w_dat[8*b +: 8];
         end
      end
      if (m_r_enb) m_r_dat <= bram[m_addr];
   end

   function automatic logic [DW-1:0] init_word(input int idx);
      if (idx < 4)          return 32'h0000_0013;
      else if (idx == 'h20) return 32'h0000_0011;
      else if (idx == 'h10) return 32'h0000_0000;
      else                  return (idx * 32'h0101_0101) ^ 32'hA5A5_0000;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: check at the falling edge, advance the model, return #1 after the rising edge.
   task automatic step();
      logic ei, ed, rd;
      @(negedge clk);
      ei = 1'b0;
      ed = 1'b0;
      if (rst_n && d_req && !(i_req && ref_run == MAX_RUN)) ed = 1'b1;
      else if (rst_n && i_req)                              ei = 1'b1;
      rd = ei | (ed & ~d_we);
      check_eq("i_gnt", i_gnt, ei);
      check_eq("d_gnt", d_gnt, ed);
      check_eq("m_r_enb", m_r_enb, rd);
      check_eq("m_w_enb", m_w_enb, ed & d_we);
      if (ed) begin
         check_eq("m_addr_d", m_addr, d_addr);
         if (d_we) begin
            check_eq("m_w_dat", m_w_dat, d_wdata);
            check_eq("m_byte_enb", m_byte_enb, d_be);
         end
      end else if (ei) begin
         check_eq("m_addr_i", m_addr, i_addr);
         check_eq("m_byte_enb_i", m_byte_enb, 4'b0000);
      end else begin
         check_eq("m_addr_idle", m_addr, i_addr);
         check_eq("m_w_dat_idle", m_w_dat, 32'h0);
         check_eq("m_byte_enb_idle", m_byte_enb, 4'b0000);
      end
      check_eq("i_rvalid", i_rvalid, exp_rv_i & rst_n);
      check_eq("d_rvalid", d_rvalid, exp_rv_d & rst_n);
      check_eq("rvalid_excl", i_rvalid & d_rvalid, 1'b0);
      if (rst_n && exp_rv_i) check_eq("i_rdata", i_rdata, exp_rdata);
      if (rst_n && exp_rv_d) check_eq("d_rdata", d_rdata, exp_rdata);
      obs_i_gnt    = i_gnt;
      obs_d_gnt    = d_gnt;
      obs_d_rvalid = d_rvalid;
      obs_d_rdata  = d_rdata;
      if (!rst_n) begin
         ref_run  = 0;
         exp_rv_i = 1'b0;
         exp_rv_d = 1'b0;
      end else begin
         exp_rv_i = ei;
         exp_rv_d = ed & ~d_we;
         if (ei) exp_rdata = ref_mem[i_addr];
         if (ed && !d_we) exp_rdata = ref_mem[d_addr];
         if (ed && d_we) begin
            for (int b = 0; b < 4; b++) begin
               if (d_be[b]) ref_mem[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
            end
         end
         if (ei || !i_req) ref_run = 0;
         else if (ed)      ref_run = (ref_run < MAX_RUN) ? ref_run + 1 : MAX_RUN;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < 4096; k++) begin
         bram[k]    = init_word(k);
         ref_mem[k] = init_word(k);
      end
      ref_run  = 0;
      exp_rv_i = 1'b0;
      exp_rv_d = 1'b0;
      exp_rdata = 32'h0;
      rst_n   = 1'b0;
      i_req   = 1'b1;
      d_req   = 1'b1;
      d_we    = 1'b0;
      i_addr  = 12'h000;
      d_addr  = 12'h020;
      d_wdata = 32'h0;
      d_be    = 4'b0000;

      // Reset with both requests high, then release.
      step();
      step();
      rst_n = 1'b1;
      step();
      check_eq("rel_d_gnt", obs_d_gnt, 1'b1);

      // Fetch only, addresses 0..3.
      d_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         i_addr = 12'(k);
         step();
         check_eq("fetch_gnt", obs_i_gnt, 1'b1);
      end
      i_req = 1'b0;
      step();

      // Contention: d,d,d,d,i repeating.
      i_req = 1'b1;
      d_req = 1'b1;
      d_we  = 1'b0;
      for (int k = 0; k < 10; k++) begin
         d_addr = 12'(k);
         step();
         check_eq("cont_pat", obs_d_gnt, (k % 5) != 4);
      end

      // Partial write, then read back the same word next cycle.
      i_req   = 1'b0;
      d_we    = 1'b1;
      d_addr  = 12'h010;
      d_wdata = 32'hDEAD_BEEF;
      d_be    = 4'b0011;
      step();
      d_we = 1'b0;
      step();
      check_eq("wr_no_rvalid", obs_d_rvalid, 1'b0);
      d_req = 1'b0;
      step();
      check_eq("wr_readback", obs_d_rdata, 32'h0000_BEEF);

      // Interleaved data then fetch read.
      d_req  = 1'b1;
      d_addr = 12'h020;
      step();
      d_req  = 1'b0;
      i_req  = 1'b1;
      i_addr = 12'h000;
      step();
      i_req = 1'b0;
      step();
      step();

      // Reset right after a read grant drops its return and clears the run.
      d_req  = 1'b1;
      d_addr = 12'h020;
      step();
      rst_n = 1'b0;
      d_req = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      check_eq("rst_drop", obs_d_rvalid, 1'b0);
      i_req = 1'b1;
      d_req = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check_eq("post_rst_pat", obs_d_gnt, k != 4);
      end

      // Random traffic against the reference model.
      for (int c = 0; c < 400; c++) begin
         if (!i_req || obs_i_gnt || $urandom_range(0, 15) == 0) begin
            i_req  = ($urandom_range(0, 3) != 0);
            i_addr = 12'($urandom_range(0, 15));
         end
         if (!d_req || obs_d_gnt || $urandom_range(0, 15) == 0) begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = 12'($urandom_range(0, 15));
            d_wdata = $urandom;
            d_be    = 4'($urandom_range(0, 15));
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
